// File: rtl/loop_cnt_ctrl.sv
// loop_cnt_ctrl: sequences an external loadable counter through a modulo-2^len index range
module loop_cnt_ctrl #(
    parameter int len = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           abort,
    input  logic           stall,
    input  logic [len-1:0] startVal,
    input  logic [len-1:0] endVal,
    input  logic [len-1:0] cntVal,
    output logic           wrt,
    output logic           cnt,
    output logic [len-1:0] dataIn,
    output logic           busy,
    output logic           iterValid,
    output logic           last,
    output logic           done
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t         r_state;
    state_t         w_next;
    logic [len-1:0] r_start_reg;
    logic [len-1:0] r_end_reg;
    logic           w_at_end;
    assign w_at_end = (cntVal == r_end_reg);
    // state register and loop bounds, bounds captured only when a start is accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_start_reg <= '0;
            r_end_reg   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_start_reg <= startVal;
                r_end_reg   <= endVal;
            end
        end
    end
    // next state and strobes; the index itself always comes from the counter via cntVal
    always_comb begin
        w_next    = r_state;
        wrt       = 1'b0;
        cnt       = 1'b0;
        iterValid = 1'b0;
        last      = 1'b0;
        done      = 1'b0;
        busy      = (r_state != IDLE);
        dataIn    = r_start_reg;
        case (r_state)
            IDLE: w_next = start ? LOAD : IDLE;
            LOAD: begin
                wrt    = 1'b1;
                w_next = abort ? IDLE : RUN;
            end
            RUN: begin
                last      = w_at_end;
                iterValid = !stall && !abort;
                cnt       = !stall && !abort && !w_at_end;
                w_next    = abort ? IDLE : (!stall && w_at_end) ? DONE : RUN;
            end
            default: begin
                done   = 1'b1;
                w_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_loop_cnt_ctrl.sv
// tb_loop_cnt_ctrl: directed and randomized checks of loop_cnt_ctrl against an index-sequence model
module tb_loop_cnt_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       stall = 1'b0;
    logic [4:0] startVal = '0;
    logic [4:0] endVal = '0;
    logic [4:0] cntVal;
    logic       wrt, cnt, busy, iterValid, last, done;
    logic [4:0] dataIn;
    int n_cmp = 0;
    int n_fail = 0;
    logic [4:0] q[$];
    logic [4:0] exp_q[$];
    int last_cnt, done_cnt, cnt_cnt, stall_bad, din_bad, timeout;

    loop_cnt_ctrl #(.len(5)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .stall(stall),
        .startVal(startVal), .endVal(endVal), .cntVal(cntVal),
        .wrt(wrt), .cnt(cnt), .dataIn(dataIn), .busy(busy),
        .iterValid(iterValid), .last(last), .done(done)
    );

    always #5 clk = ~clk;

    // external loadable counter that the controller drives
    always @(posedge clk) begin
        if (reset) cntVal <= '0;
        else if (wrt) cntVal <= dataIn;
        else if (cnt) cntVal <= cntVal + 5'd1;
    end

    function automatic void build_exp(input logic [4:0] sv, input logic [4:0] ev);
        logic [4:0] span;
        exp_q.delete();
        span = ev - sv;
        for (int i = 0; i <= int'(span); i++) exp_q.push_back(5'(int'(sv) + i));
    endfunction

    task automatic do_loop(input logic [4:0] sv, input logic [4:0] ev, input int stall_pct, input bit noise);
        q.delete();
        last_cnt = 0; done_cnt = 0; cnt_cnt = 0; stall_bad = 0; din_bad = 0; timeout = 0;
        @(posedge clk); #1;
        start = 1'b1; startVal = sv; endVal = ev;
        @(posedge clk); #1;
        start = 1'b0; startVal = 5'($urandom); endVal = 5'($urandom);
        for (int c = 0; c < 400; c++) begin
            stall = ($urandom_range(99) < stall_pct);
            start = noise ? 1'($urandom_range(1)) : 1'b0;
            startVal = 5'($urandom); endVal = 5'($urandom);
            @(negedge clk);
            if (iterValid) q.push_back(cntVal);
            if (iterValid && last) last_cnt++;
            if (cnt) cnt_cnt++;
            if (stall && (cnt || iterValid)) stall_bad++;
            if (dataIn !== sv) din_bad++;
            if (done) begin
                done_cnt++;
                break;
            end
            @(posedge clk); #1;
        end
        if (done_cnt == 0) timeout = 1;
        start = 1'b0; stall = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({wrt, cnt, iterValid, last, done, busy} !== 6'b0 || dataIn !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got flags=%b dataIn=%0d want flags=000000 dataIn=0", {wrt, cnt, iterValid, last, done, busy}, dataIn);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_basic;
        @(posedge clk); #1;
        start = 1'b1; startVal = 5'd3; endVal = 5'd6;
        @(posedge clk); #1;
        start = 1'b0; startVal = 5'd20; endVal = 5'd21;
        @(negedge clk);
        n_cmp++;
        if (wrt !== 1'b1 || busy !== 1'b1 || dataIn !== 5'd3 || cnt !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_load: got wrt=%b busy=%b dataIn=%0d cnt=%b want 1 1 3 0", wrt, busy, dataIn, cnt);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            n_cmp++;
            if (iterValid !== 1'b1 || cntVal !== 5'(3 + i) || last !== (i == 3) || done !== 1'b0 || wrt !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_iter%0d: got iv=%b idx=%0d last=%b done=%b wrt=%b want 1 %0d %b 0 0", i, iterValid, cntVal, last, done, wrt, 3 + i, i == 3);
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || iterValid !== 1'b0 || cnt !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: got done=%b iv=%b cnt=%b want 1 0 0", done, iterValid, cnt);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_wrap;
        do_loop(5'd30, 5'd1, 0, 1'b0);
        build_exp(5'd30, 5'd1);
        n_cmp++;
        if (q !== exp_q || last_cnt !== 1 || timeout !== 0) begin
            n_fail++;
            $display("FAIL wrap_seq: got n=%0d last=%0d first=%0d want n=4 last=1 seq 30,31,0,1", q.size(), last_cnt, q.size() ? q[0] : 5'd0);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_single;
        do_loop(5'd9, 5'd9, 0, 1'b0);
        n_cmp++;
        if (q.size() !== 1 || last_cnt !== 1 || cnt_cnt !== 0 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL single_iter: got n=%0d last=%0d cnt=%0d done=%0d want 1 1 0 1", q.size(), last_cnt, cnt_cnt, done_cnt);
        end
        n_cmp++;
        if (q.size() == 1 && q[0] !== 5'd9) begin
            n_fail++;
            $display("FAIL single_idx: got %0d want 9", q[0]);
        end
    endtask

    task automatic test_stall;
        int n_iv;
        bit got_done;
        n_iv = 0; got_done = 0;
        @(posedge clk); #1;
        start = 1'b1; startVal = 5'd0; endVal = 5'd4;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        repeat (2) begin
            @(negedge clk);
            if (iterValid) n_iv++;
            @(posedge clk); #1;
        end
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            n_cmp++;
            if (cntVal !== 5'd2 || cnt !== 1'b0 || iterValid !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got idx=%0d cnt=%b iv=%b busy=%b want 2 0 0 1", s, cntVal, cnt, iterValid, busy);
            end
            @(posedge clk); #1;
        end
        stall = 1'b0;
        for (int c = 0; c < 20 && !got_done; c++) begin
            @(negedge clk);
            if (iterValid) n_iv++;
            if (done) got_done = 1;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (n_iv !== 5 || got_done !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_total: got iters=%0d done=%b want 5 1", n_iv, got_done);
        end
    endtask

    task automatic test_abort;
        bit saw_done;
        saw_done = 0;
        @(posedge clk); #1;
        start = 1'b1; startVal = 5'd0; endVal = 5'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 abort = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (cntVal !== 5'd2 || iterValid !== 1'b0 || cnt !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_cycle: got idx=%0d iv=%b cnt=%b want 2 0 0", cntVal, iterValid, cnt);
        end
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got busy=%b done=%b want 0 0", busy, done);
        end
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        n_cmp++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_quiet: got activity=%b want 0", saw_done);
        end
        #1;
        do_loop(5'd5, 5'd5, 0, 1'b0);
        n_cmp++;
        if (q.size() !== 1 || (q.size() == 1 && q[0] !== 5'd5) || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL abort_restart: got n=%0d done=%0d want n=1 idx=5 done=1", q.size(), done_cnt);
        end
    endtask

    task automatic test_reset_midrun;
        @(posedge clk); #1;
        start = 1'b1; startVal = 5'd0; endVal = 5'd20;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1; start = 1'b1; startVal = 5'd7; endVal = 5'd8;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if ({wrt, cnt, iterValid, last, done, busy} !== 6'b0 || dataIn !== 5'd0) begin
            n_fail++;
            $display("FAIL rst_mid_out: got flags=%b dataIn=%0d want 000000 0", {wrt, cnt, iterValid, last, done, busy}, dataIn);
        end
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (wrt !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_noload: got wrt=%b busy=%b done=%b want 0 0 0", wrt, busy, done);
        end
        #1;
    endtask

    task automatic test_random;
        logic [4:0] sv, ev;
        for (int k = 0; k < 20; k++) begin
            sv = 5'($urandom); ev = 5'($urandom);
            do_loop(sv, ev, 30, 1'b1);
            build_exp(sv, ev);
            n_cmp++;
            if (q !== exp_q || last_cnt !== 1 || done_cnt !== 1 || stall_bad !== 0 || din_bad !== 0 || timeout !== 0) begin
                n_fail++;
                $display("FAIL rand%0d sv=%0d ev=%0d: got n=%0d last=%0d done=%0d stallbad=%0d dinbad=%0d to=%0d want n=%0d 1 1 0 0 0",
                         k, sv, ev, q.size(), last_cnt, done_cnt, stall_bad, din_bad, timeout, exp_q.size());
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_wrap;
        test_single;
        test_stall;
        test_abort;
        test_reset_midrun;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
